// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive-side byte buffer for the Uart8 receiver. Captures
//               {rxErr, rxOut} on each rising edge of rxDone into a
//               first-word-fall-through FIFO, drained through valid/ready.
//               Bytes arriving while full are dropped and recorded by a
//               sticky overflow flag and a saturating 8-bit drop counter.
// Ports       : clk, reset (async, active-low)
//               rxDone/rxOut/rxErr  - byte strobe, data and framing error
//               flush               - sync clear of contents (flags kept)
//               outValid/outData/outErr/outReady - FWFT consumer side
//               count/full          - registered occupancy
//               overflow/dropCount/ovfClear - loss tracking and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxDone,
  input  logic [7:0]        rxOut,
  input  logic              rxErr,
  input  logic              flush,
  output logic              outValid,
  output logic [7:0]        outData,
  output logic              outErr,
  input  logic              outReady,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  output logic [7:0]        dropCount,
  input  logic              ovfClear
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_next;
  logic              full_q;
  logic              overflow_q;
  logic [7:0]        drop_count_q;
  logic              rx_done_q;

  logic              push_evt;
  logic              pop;
  logic              push_ok;
  logic              drop;

  // Edge register resets high so a strobe already asserted when reset is
  // released is not mistaken for a new byte.
  assign push_evt = rxDone & ~rx_done_q;

  // Valid comes from registered occupancy only, so outReady never reaches
  // outValid/outData combinationally.
  assign outValid = (count_q != '0);
  assign pop      = outValid & outReady & ~flush;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push_ok  = push_evt & (~full_q | pop) & ~flush;
  assign drop     = push_evt & full_q & ~pop & ~flush;

  always_comb begin
    count_next = count_q;
    if (flush) begin
      count_next = '0;
    end else if (push_ok && !pop) begin
      count_next = count_q + (ADDR_W+1)'(1);
    end else if (pop && !push_ok) begin
      count_next = count_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_done_q <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
    end else begin
      rx_done_q <= rxDone;
      count_q   <= count_next;
      full_q    <= (count_next == FULL_COUNT);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)     rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Storage carries no reset; the read side is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {rxErr, rxOut};
  end

  // A drop coinciding with ovfClear wins: the counter restarts at one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= 8'h00;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (ovfClear)                  drop_count_q <= 8'd1;
      else if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
    end else if (ovfClear) begin
      overflow_q   <= 1'b0;
      drop_count_q <= 8'h00;
    end
  end

  assign outData   = outValid ? mem[rd_ptr][7:0] : 8'h00;
  assign outErr    = outValid ? mem[rd_ptr][8]   : 1'b0;
  assign count     = count_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign dropCount = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. A reference model with
//               a scoreboard queue predicts every entry, occupancy and the
//               overflow/drop state; heads are compared as they are popped.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       reset;
  logic       rxDone;
  logic [7:0] rxOut;
  logic       rxErr;
  logic       flush;
  logic       outValid;
  logic [7:0] outData;
  logic       outErr;
  logic       outReady;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] dropCount;
  logic       ovfClear;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxDone    (rxDone),
    .rxOut     (rxOut),
    .rxErr     (rxErr),
    .flush     (flush),
    .outValid  (outValid),
    .outData   (outData),
    .outErr    (outErr),
    .outReady  (outReady),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .dropCount (dropCount),
    .ovfClear  (ovfClear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks;
  int         n_fail;
  logic [8:0] sb[$];
  int         m_ovf;
  int         m_dc;
  bit         prev_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_checks++;
    if (obs !== expd) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expd, $time);
    end
  endtask

  task automatic check_state();
    check("count", count, sb.size());
    check("full", full, sb.size() == DEPTH);
    check("outValid", outValid, sb.size() != 0);
    if (sb.size() != 0) begin
      check("outData", outData, sb[0][7:0]);
      check("outErr", outErr, sb[0][8]);
    end
    check("overflow", overflow, m_ovf);
    check("dropCount", dropCount, m_dc);
  endtask

  // One clock: drive inputs, advance the model, cross the edge, compare.
  task automatic step(input bit done, input logic [7:0] data, input bit err,
                      input bit rdy, input bit fl, input bit oc);
    bit push_evt;
    bit pop;
    bit accept;
    bit drop;
    int size_before;
    rxDone = done; rxOut = data; rxErr = err;
    outReady = rdy; flush = fl; ovfClear = oc;
    push_evt    = done && !prev_done;
    size_before = sb.size();
    pop         = (size_before != 0) && rdy;
    accept      = 1'b0;
    drop        = 1'b0;
    if (fl) begin
      sb.delete();
    end else begin
      accept = push_evt && ((size_before < DEPTH) || pop);
      drop   = push_evt && !accept;
      if (pop) begin
        check("pop_head", {outErr, outData}, sb[0]);
        void'(sb.pop_front());
      end
      if (accept) sb.push_back({err, data});
    end
    if (drop) begin
      m_ovf = 1;
      m_dc  = oc ? 1 : ((m_dc == 255) ? 255 : m_dc + 1);
    end else if (oc) begin
      m_ovf = 0;
      m_dc  = 0;
    end
    prev_done = done;
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic push(input logic [7:0] b, input bit e, input bit rdy);
    step(1'b1, b, e, rdy, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outValid"}, outValid, 0);
    check({tag, "_outData"}, outData, 0);
    check({tag, "_outErr"}, outErr, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_dropCount"}, dropCount, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    m_ovf = 0; m_dc = 0; prev_done = 1'b1;
    reset = 1'b0; rxDone = 1'b1; rxOut = 8'h00; rxErr = 1'b0;
    flush = 1'b0; outReady = 1'b0; ovfClear = 1'b0;
    #2;
    check_reset_outputs("rst");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // 1: rxDone high across release must not push; then one byte round trip
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // 2: fill, one drop, drain in order
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0, 1'b0);
    push(8'hAA, 1'b0, 1'b0);
    idle(DEPTH, 1'b1);

    // 3: push into a full FIFO together with a pop
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(DEPTH, 1'b1);

    // 4: error flag travels with its byte
    push(8'hB5, 1'b1, 1'b0);
    push(8'h3C, 1'b0, 1'b0);
    idle(2, 1'b1);

    // 5: drop counter saturation and clear interplay
    for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) push(8'hEE, 1'b0, 1'b0);
    check("dc_saturated", dropCount, 255);
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("dc_clear_and_drop", dropCount, 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_cleared", overflow, 0);
    idle(DEPTH, 1'b1);

    // 6: flush with concurrent push/pop keeps overflow, then async reset
    for (int i = 0; i < DEPTH; i++) push(8'(8'h40 + i), 1'b0, 1'b0);
    push(8'hDD, 1'b0, 1'b0);
    idle(DEPTH - 5, 1'b1);
    check("pre_flush_count", count, 5);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0);
    check("flush_ovf_kept", overflow, 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i), 1'b0, 1'b0);
    idle(1, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    sb.delete(); m_ovf = 0; m_dc = 0; prev_done = 1'b1;
    rxDone = 1'b0; outReady = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2, 1'b0);
    push(8'h5C, 1'b0, 1'b0);
    idle(1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the Uart8 receiver. It captures each completed byte (rxOut) and its error flag (rxErr) on the rising edge of rxDone, and stores them in a first-word-fall-through FIFO. Consumers drain it through a valid/ready interface. Overflow is tracked with a sticky flag and a saturating drop counter, so host logic can detect lost bytes.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 2
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rxDone  input  1  from Uart8; rising edge marks a new byte on rxOut/rxErr
rxOut  input  8  received byte from Uart8
rxErr  input  1  framing error for the byte presented with rxDone
flush  input  1  synchronous clear of FIFO contents; flags are kept
outValid  output  1  head entry available
outData  output  8  head byte; valid only while outValid=1
outErr  output  1  error flag of head entry
outReady  input  1  consumer accepts head when outValid&&outReady
count  output  ADDR_W+1  current occupancy, 0..DEPTH
full  output  1  count==DEPTH
overflow  output  1  sticky; set when a byte is dropped
dropCount  output  8  number of dropped bytes, saturates at 255
ovfClear  input  1  synchronous clear of overflow and dropCount

Behaviour:
- Reset (reset=0, asynchronous):
  - pointers=0, count=0, outValid=0, outData=0, outErr=0, full=0, overflow=0, dropCount=0.
  - The rxDone edge register resets to 1, so an rxDone already high at reset release does not cause a push.
- Push event: rxDone==1 and the registered rxDone from the previous cycle ==0.
  - {rxErr, rxOut} is sampled in that same cycle.
  - A level held high produces exactly one push.
- Storage: DEPTH x 9-bit array holding {err, byte}. Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0. count is kept explicitly.
- Pop: outValid && outReady. The head advances at that clock edge.
- FWFT latency: a push into an empty FIFO at edge N gives outValid=1 with that data after edge N (visible in cycle N+1). No extra read latency.
- outData/outErr are stable while outValid=1 and outReady=0.
- Simultaneous push and pop:
  - count unchanged.
  - Push is accepted even when full, because the pop frees a slot.
  - On an empty FIFO no pop can occur, so only the push takes effect.
- Push when full and no pop in the same cycle:
  - Byte discarded; contents untouched.
  - overflow<=1.
  - dropCount<=dropCount+1 unless already 255.
- ovfClear: clears overflow and dropCount. If a drop happens in the same cycle, the drop wins: overflow=1, dropCount=1.
- flush:
  - pointers and count go to 0, outValid=0 next cycle.
  - A push or pop in the same cycle is ignored.
  - overflow and dropCount are unaffected.
- Flag timing: full and count are registered and track occupancy after each edge.
- rxErr bytes are stored like any other byte (not filtered); outErr reports them.
- No combinational path from outReady to outValid or outData.

Test Plan:
1. Reset release with rxDone held high, then 0x5A pushed (rxDone 0->1, rxErr=0) -> no push at release; after the 0x5A edge, next cycle outValid=1, outData=0x5A, outErr=0, count=1; pop with outReady=1 -> outValid=0, count=0.
2. Push 16 bytes 0x00..0x0F with outReady=0 -> full=1, count=16; a 17th byte 0xAA -> dropped, overflow=1, dropCount=1; drain -> 0x00..0x0F in order, 0xAA absent.
3. When full, push 0x77 in the same cycle as a pop -> count stays 16, full=1, overflow stays 0; 0x77 becomes the last entry drained.
4. Push 0xB5 with rxErr=1, then 0x3C with rxErr=0 -> outErr=1 at head 0xB5, outErr=0 at head 0x3C.
5. Overflow 300 times on a full FIFO -> dropCount=255 (saturated); ovfClear together with one more drop -> overflow=1, dropCount=1; ovfClear alone -> overflow=0, dropCount=0.
6. Hold 5 entries, pulse flush with simultaneous push and pop -> count=0, outValid=0, overflow unchanged; pull reset low mid-drain -> all outputs immediately 0.
